// File: rtl/vend_fsm_param.sv
// Vending-machine controller: one-hot Moore FSM (IDLE/COLLECT/VEND/CHANGE) with a credit accumulator.
// Optional inactivity refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_fsm_param #(
    parameter int COIN_W      = 2,
    parameter int PRICE       = 3,
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_vld,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                cancel,
    output logic                coin_rdy,
    output logic                vend_vld,
    output logic                chg_vld,
    output logic                chg_busy,
    output logic [CREDIT_W-1:0] credit
);

    // Largest credit ever held is PRICE-1 plus the biggest coin.
    generate
        if (PRICE < 1 || (PRICE - 1 + (2**COIN_W - 1)) > (2**CREDIT_W - 1)) begin : g_bad_width
            $error("vend_fsm_param: CREDIT_W too small for PRICE and COIN_W");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        COLLECT = 4'b0010,
        VEND    = 4'b0100,
        CHANGE  = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] nc;
    logic                coin_acc;
    logic                refund_req;
    logic                expire;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d  = '0;
        expire = (state_q == COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
        if (state_q == COLLECT && !coin_acc) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    assign coin_rdy   = (state_q == IDLE) || (state_q == COLLECT);
    assign coin_acc   = coin_vld && coin_rdy && (coin_val != '0);
    assign nc         = credit_q + (coin_acc ? CREDIT_W'(coin_val) : '0);
    assign refund_req = (state_q == COLLECT) && (cancel || expire);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            IDLE, COLLECT: begin
                // A coin is counted before a same-cycle cancel; reaching PRICE drops the cancel.
                if (coin_acc && nc >= PRICE_C) begin
                    state_d  = VEND;
                    credit_d = nc;
                end else if (refund_req && nc != '0) begin
                    state_d  = CHANGE;
                    credit_d = nc;
                end else if (coin_acc) begin
                    state_d  = COLLECT;
                    credit_d = nc;
                end
            end
            VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_q <= CREDIT_W'(1)) begin
                    state_d  = IDLE;
                    credit_d = '0;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end
    end

    assign vend_vld = (state_q == VEND);
    assign chg_vld  = (state_q == CHANGE);
    assign chg_busy = (state_q == CHANGE);
    assign credit   = credit_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Randomized and directed bench for vend_fsm_param against an arithmetic credit/refund model.
// Define VEND_TIMEOUT_EN to also exercise the inactivity refund (TIMEOUT_CYC=8).
module tb_vend_fsm_param;
    localparam int COIN_W   = 2;
    localparam int PRICE    = 3;
    localparam int CREDIT_W = 4;
    localparam int TMO      = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                coin_vld = 1'b0;
    logic [COIN_W-1:0]   coin_val = '0;
    logic                cancel = 1'b0;
    logic                coin_rdy, vend_vld, chg_vld, chg_busy;
    logic [CREDIT_W-1:0] credit;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: money held, a pending sale flag and units still to pay out.
    int m_credit;
    bit m_vend;
    int m_chg;
    int m_idle;

    vend_fsm_param #(.COIN_W(COIN_W), .PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .coin_vld(coin_vld), .coin_val(coin_val), .cancel(cancel),
        .coin_rdy(coin_rdy), .vend_vld(vend_vld), .chg_vld(chg_vld), .chg_busy(chg_busy),
        .credit(credit)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_vec();
        return {coin_rdy, vend_vld, chg_vld, chg_busy, credit};
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] c;
        c = 4'(m_credit);
        return {(!m_vend && m_chg == 0), m_vend, (m_chg > 0), (m_chg > 0), c};
    endfunction

    function automatic void model_reset();
        m_credit = 0; m_vend = 0; m_chg = 0; m_idle = 0;
    endfunction

    function automatic void model_step(input bit v, input int val, input bit can);
        bit acc, collecting, timed_out;
        int nc;
        collecting = !m_vend && m_chg == 0 && m_credit > 0;
        if (m_vend) begin
            m_vend = 0;
            m_credit = m_credit - PRICE;
            m_chg = m_credit;
            m_idle = 0;
        end else if (m_chg > 0) begin
            m_chg = m_chg - 1;
            m_credit = m_chg;
            m_idle = 0;
        end else begin
            acc = v && val != 0;
            nc = m_credit + (acc ? val : 0);
            timed_out = 0;
`ifdef VEND_TIMEOUT_EN
            timed_out = collecting && !acc && m_idle == TMO - 1;
`endif
            m_credit = nc;
            if (acc && nc >= PRICE) m_vend = 1;
            else if (collecting && (can || timed_out) && nc > 0) m_chg = nc;
            m_idle = (collecting && !acc) ? m_idle + 1 : 0;
        end
    endfunction

    // Apply inputs across one rising edge, advance the model, settle 1 time unit after the edge.
    task automatic cycle(input bit v, input int val, input bit can);
        coin_vld = v;
        coin_val = COIN_W'(val);
        cancel   = can;
        @(posedge clk);
        model_step(v, val, can);
        #1;
        cyc++;
        $display("cyc %0d coin_vld=%0d coin_val=%0d cancel=%0d -> rdy=%0d vend=%0d chg=%0d busy=%0d credit=%0d",
                 cyc, v, val, can, coin_rdy, vend_vld, chg_vld, chg_busy, credit);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        coin_vld = 1'b0; cancel = 1'b0; coin_val = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 8'b1000_0000) begin
            fails++;
            $display("FAIL reset_state: got %b want %b", obs_vec(), 8'b1000_0000);
        end
    endtask

    // Directed scenarios: each entry is {coin_vld, coin_val, cancel}, checked every cycle.
    task automatic run_seq(input string name, input int seq[$][3], input int want_vend, input int want_chg);
        int nv = 0, nch = 0;
        do_reset();
        foreach (seq[i]) begin
            cycle(seq[i][0] != 0, seq[i][1], seq[i][2] != 0);
            nv += vend_vld; nch += chg_vld;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL %s step %0d: got %b want %b", name, i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (nv != want_vend || nch != want_chg || credit !== '0 || coin_rdy !== 1'b1) begin
            fails++;
            $display("FAIL %s totals: vend %0d/%0d chg %0d/%0d credit %0d rdy %0d (want vend %0d chg %0d credit 0 rdy 1)",
                     name, nv, want_vend, nch, want_chg, credit, coin_rdy, want_vend, want_chg);
        end
    endtask

    task automatic test_directed();
        int s1[$][3] = '{'{1,1,0}, '{1,1,0}, '{1,1,0}, '{0,0,0}, '{0,0,0}};
        int s2[$][3] = '{'{1,2,0}, '{1,2,0}, '{0,0,0}, '{0,0,0}, '{0,0,0}};
        int s3[$][3] = '{'{1,3,0}, '{1,3,0}, '{0,0,0}, '{0,0,0}};
        int s4[$][3] = '{'{1,2,0}, '{0,0,1}, '{0,0,0}, '{0,0,0}, '{0,0,0}};
        int s5[$][3] = '{'{1,2,0}, '{1,1,1}, '{0,0,0}, '{0,0,0}};
        int s6[$][3] = '{'{0,0,1}, '{1,1,1}, '{0,0,1}, '{0,0,1}, '{0,0,0}, '{0,0,0}};
        run_seq("coins_111", s1, 1, 0);
        run_seq("coins_22", s2, 1, 1);
        run_seq("coin3_drop", s3, 1, 0);
        run_seq("cancel_refund", s4, 0, 2);
        run_seq("coin_cancel_vend", s5, 1, 0);
        run_seq("idle_cancel", s6, 0, 1);
    endtask

    task automatic test_credit_values();
        do_reset();
        cycle(1, 1, 0);
        checks++;
        if (credit !== 4'd1) begin fails++; $display("FAIL credit_after_1: got %0d want 1", credit); end
        cycle(1, 1, 0);
        checks++;
        if (credit !== 4'd2) begin fails++; $display("FAIL credit_after_2: got %0d want 2", credit); end
        cycle(1, 1, 0);
        checks++;
        if (vend_vld !== 1'b1 || coin_rdy !== 1'b0) begin
            fails++; $display("FAIL vend_latency: vend %0d rdy %0d want 1 0", vend_vld, coin_rdy);
        end
        cycle(0, 0, 0);
        checks++;
        if (vend_vld !== 1'b0 || chg_vld !== 1'b0 || credit !== 4'd0) begin
            fails++; $display("FAIL vend_single: vend %0d chg %0d credit %0d want 0 0 0", vend_vld, chg_vld, credit);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 2, 0);
        cycle(0, 0, 1);
        checks++;
        if (chg_busy !== 1'b1 || credit !== 4'd2) begin
            fails++; $display("FAIL pre_reset_change: busy %0d credit %0d want 1 2", chg_busy, credit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({coin_rdy, vend_vld, chg_vld, chg_busy, credit} !== 8'b1000_0000) begin
            fails++; $display("FAIL async_reset: got %b want %b", obs_vec(), 8'b1000_0000);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        cycle(0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL post_reset_idle: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL random cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        cycle(1, 1, 0);
        for (int i = 1; i <= TMO; i++) begin
            cycle(0, 0, 0);
            checks++;
            if (chg_vld !== (i == TMO) || obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL timeout idle %0d: chg %0d vec %b want chg %0d vec %b",
                                  i, chg_vld, obs_vec(), i == TMO, exp_vec());
            end
        end
        do_reset();
        cycle(1, 1, 0);
        repeat (TMO - 2) cycle(0, 0, 0);
        cycle(1, 1, 0);
        for (int i = 1; i <= TMO; i++) begin
            cycle(0, 0, 0);
            checks++;
            if (chg_vld !== (i == TMO) || obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL timeout restart %0d: chg %0d vec %b want chg %0d vec %b",
                                  i, chg_vld, obs_vec(), i == TMO, exp_vec());
            end
        end
    endtask
`else
    task automatic test_hold();
        do_reset();
        cycle(1, 2, 0);
        repeat (30) cycle(0, 0, 0);
        checks++;
        if (chg_vld !== 1'b0 || credit !== 4'd2 || coin_rdy !== 1'b1) begin
            fails++; $display("FAIL hold_credit: chg %0d credit %0d rdy %0d want 0 2 1", chg_vld, credit, coin_rdy);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_credit_values();
        test_async_reset();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
